// File: rtl/ita_hwpe_input_splitter.sv
// Splits 2*DW-bit input beats into two DW-bit engine beats, low half first,
// counting engine beats against a programmed length.
module ita_hwpe_input_splitter #(
    parameter int unsigned DW    = 128,
    parameter int unsigned LEN_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [LEN_W-1:0] tot_len_i,
    input  logic [2*DW-1:0] in_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic [DW-1:0]   out_data_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_last_o,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state_q, state_d;
    logic [2*DW-1:0]    data_q, data_d;
    logic               valid_q, valid_d;
    logic               hp_q, hp_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LEN_W-1:0]   wide_q, wide_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   n_wide;
    logic               run, in_hs, out_hs;

    assign run = (state_q == RUN);
    assign n_wide = (tot_len_i >> 1)
                  + {{(LEN_W-1){1'b0}}, tot_len_i[0]};

    assign out_data_o  = hp_q ? data_q[2*DW-1:DW] : data_q[DW-1:0];
    assign out_valid_o = valid_q;
    assign out_last_o  = valid_q && (rem_q == LEN_W'(1));
    // wide_q holds the wide beats still to fetch; the upper-half case
    // lets a refill overlap the final handshake of the current beat
    assign in_ready_o  = run && (wide_q != '0)
                      && (!valid_q
                          || (hp_q && out_ready_i && rem_q > LEN_W'(1)));
    assign in_hs  = in_valid_i && in_ready_o;
    assign out_hs = valid_q && out_ready_i;
    assign busy_o = run;
    assign done_o = done_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        hp_d    = hp_q;
        rem_d   = rem_q;
        wide_d  = wide_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            hp_d    = 1'b0;
            rem_d   = '0;
            wide_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (tot_len_i != '0) begin
                            state_d = RUN;
                            rem_d   = tot_len_i;
                            wide_d  = n_wide;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (out_hs) begin
                        rem_d = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            valid_d = 1'b0;
                            hp_d    = 1'b0;
                            wide_d  = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else if (!hp_q) begin
                            hp_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            hp_d    = 1'b0;
                        end
                    end
                    if (in_hs) begin
                        data_d  = in_data_i;
                        valid_d = 1'b1;
                        hp_d    = 1'b0;
                        wide_d  = wide_q - LEN_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            hp_q    <= 1'b0;
            rem_q   <= '0;
            wide_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hp_q    <= hp_d;
            rem_q   <= rem_d;
            wide_q  <= wide_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/ita_hwpe_input_splitter.md
Name: ita_hwpe_input_splitter

Overview:
- Sits between the input source streamer and the ITA engine input port.
- The input source streamer delivers 2*N-byte beats: tot_len = M*M/N/2, stride 2*ITA_INPUT_DW/8.
- This block splits each wide beat into two N-byte engine beats, low half first.
- It counts engine beats against a programmed length, flags the last beat, and pulses done when the transfer completes.

Parameters:
- DW, 128: engine-side beat width in bits (N*8). Input width is 2*DW.
- LEN_W, 16: width of the beat-length counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear; same as the HWPE clear_o.
- start_i  in  1  single-cycle start pulse from the controller.
- tot_len_i  in  LEN_W  number of DW-wide output beats; sampled on start_i.
- in_data_i  in  2*DW  wide beat from the input source.
- in_valid_i  in  1  wide beat valid.
- in_ready_o  out  1  wide beat accepted.
- out_data_o  out  DW  engine beat.
- out_valid_o  out  1  engine beat valid.
- out_ready_i  in  1  engine ready.
- out_last_o  out  1  high with the final engine beat.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (rst_ni low, async): state=IDLE; buffer empty; half pointer=0; counter=0. All outputs 0, out_data_o included.
- State IDLE:
  - start_i with tot_len_i!=0 → RUN next cycle; latch remaining=tot_len_i.
  - start_i with tot_len_i==0 → stay IDLE; done_o pulses in the next cycle.
- State RUN:
  - Holding register: one 2*DW wide buffer, a valid bit and a half pointer hp.
  - out_data_o = hp ? buf[2*DW-1:DW] : buf[DW-1:0].
  - out_valid_o = buffer valid.
  - out_last_o = out_valid_o && remaining==1.
- Output handshake (out_valid_o && out_ready_i):
  - remaining decrements.
  - If remaining was 1: buffer invalidated, hp=0, state→IDLE, done_o pulses next cycle.
  - Else if hp==0: hp=1.
  - Else: buffer invalidated, hp=0.
- in_ready_o = RUN && remaining>1-or-buffer-empty rule, defined exactly as:
  - RUN && (!buf_valid || (hp==1 && out_ready_i && remaining>1)).
  - Number of wide beats already accepted must be < ceil(tot_len/2).
  - in_ready_o never depends on in_valid_i.
- Input handshake (in_valid_i && in_ready_o): buffer loaded, buf_valid=1, hp=0.
  - A load may coincide with the upper-half handshake; the load wins, giving full throughput of one engine beat per cycle.
- Latency: wide beat accepted in cycle k → low half on out_data_o in cycle k+1.
- Output stability: while out_valid_o && !out_ready_i, out_data_o and out_last_o stay stable.
- Odd tot_len: the last wide beat's upper half is discarded. No further input is requested (wide-beat counter reaches ceil(tot_len/2)).
- Counters: remaining and wide-beat counter are LEN_W bits; no wrap, since values only decrement to 0.
- start_i while in RUN is ignored.
- clear_i (any state): next cycle IDLE, buffer empty, counters 0, no done_o pulse.
  - clear_i has priority over start_i and over handshakes in the same cycle.
- done_o and busy_o are registered. busy_o is 0 in the cycle done_o is high.

Test Plan:
- Basic split: tot_len=4, two wide beats {B,A}, {D,C}, out_ready_i=1 → out A,B,C,D in 4 consecutive cycles.
  - First out one cycle after the first input handshake.
  - out_last_o with D; done_o one cycle after D; busy_o 0 afterwards.
- Backpressure: tot_len=8, out_ready_i toggling 1,0,0,1... → data held stable while stalled.
  - in_ready_o low until the upper half is consumed.
  - Exactly 4 input handshakes, 8 output handshakes, order preserved.
- Odd length: tot_len=3 → outputs lo0, hi0, lo1.
  - Exactly 2 input handshakes; out_last_o on lo1; hi1 never output; in_ready_o stays 0 after the second beat.
- Zero length: start_i with tot_len=0 → no in_ready_o; done_o pulses next cycle; busy_o stays 0.
- Clear mid-transfer: tot_len=16, assert clear_i after 5 outputs → IDLE next cycle, no done_o.
  - A following start with tot_len=2 completes normally with fresh data.
- Async reset mid-RUN: rst_ni low while buffer full → all outputs 0 immediately; after release block is IDLE and accepts a new start.
